// File: rtl/dac_i2s_tx.sv
// rtl/dac_i2s_tx.sv - FIFO-buffered mono-to-stereo I2S transmitter clocked from clk_dac
module dac_i2s_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int BCLK_DIV     = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_dac,
  input  logic                          reset_n,
  input  logic                          sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]       sample,
  input  logic                          clear_flags,
  output logic                          bclk,
  output logic                          lrclk,
  output logic                          sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int DW    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int FRAME = 2 * SLOT_WIDTH;
  localparam int BW    = $clog2(FRAME);
  localparam int PAD   = SLOT_WIDTH - SAMPLE_WIDTH;

  if (SAMPLE_WIDTH > SLOT_WIDTH || BCLK_DIV < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("dac_i2s_tx: illegal parameter combination");
  end

  logic [DW-1:0]           div_cnt;
  logic [BW-1:0]           bit_cnt, bit_nxt;
  logic [SAMPLE_WIDTH-1:0] held, held_nxt;
  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [SLOT_WIDTH-1:0]   shift_q, shift_nxt;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic div_wrap, fall_tick, frame_start, mid_frame;
  logic fifo_empty, fifo_full, pop, push, ovf_set, unr_set;

  assign div_wrap    = (div_cnt == DW'(BCLK_DIV - 1));
  assign fall_tick   = div_wrap & bclk;
  assign bit_nxt     = (bit_cnt == BW'(FRAME - 1)) ? '0 : bit_cnt + 1'b1;
  assign frame_start = fall_tick && (bit_nxt == '0);
  assign mid_frame   = fall_tick && (bit_nxt == BW'(SLOT_WIDTH));

  // A pop only ever happens at frame start, so a same-cycle push into an empty FIFO is never bypassed
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign pop        = frame_start & ~fifo_empty;
  assign push       = sample_valid & (~fifo_full | pop);
  assign ovf_set    = sample_valid & fifo_full & ~pop;
  assign unr_set    = frame_start & fifo_empty;
  assign fifo_level = count;

  always_comb begin
    held_nxt  = held;
    shift_nxt = shift_q << 1;
    if (pop) held_nxt = mem[rd_ptr];
    if (frame_start)    shift_nxt = SLOT_WIDTH'(held_nxt) << PAD;
    else if (mid_frame) shift_nxt = SLOT_WIDTH'(held) << PAD;
  end

  always_ff @(posedge clk_dac or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= BW'(FRAME - 1);
      lrclk   <= 1'b0;
      sdata   <= 1'b0;
      held    <= '0;
      shift_q <= '0;
    end else begin
      div_cnt <= div_wrap ? '0 : div_cnt + 1'b1;
      if (div_wrap) bclk <= ~bclk;
      if (fall_tick) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= BW'(SLOT_WIDTH - 1)) && (bit_nxt <= BW'(FRAME - 2));
        held    <= held_nxt;
        shift_q <= shift_nxt;
        sdata   <= shift_nxt[SLOT_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk_dac) begin
    if (push) mem[wr_ptr] <= sample;
  end

  always_ff @(posedge clk_dac or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)          overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (unr_set)          underrun <= 1'b1;
      else if (clear_flags) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_i2s_tx.sv
// tb/tb_dac_i2s_tx.sv - scoreboard bench: per-frame I2S capture checked against queued expected samples
module tb_dac_i2s_tx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [15:0] sample;
  logic        clear_flags;
  logic        bclk, lrclk, sdata;
  logic [2:0]  fifo_level;
  logic        overflow, underrun;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [15:0] exp_q [$];

  // lrclk high for bits 31..62; bit b is stored at index 63-b
  localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

  dac_i2s_tx #(
    .SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .BCLK_DIV(2), .FIFO_DEPTH(4)
  ) dut (
    .clk_dac(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample(sample),
    .clear_flags(clear_flags), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
    .fifo_level(fifo_level), .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int k);
    int guard = 0;
    while (cyc < k && guard < 100000) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [15:0] d, input logic clr);
    goto(k - 1);
    sample_valid = v;
    sample       = d;
    clear_flags  = clr;
    goto(k);
    sample_valid = 1'b0;
    clear_flags  = 1'b0;
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_and_check(input string tag);
    reset_n = 1'b1;
    goto(1); chk({tag, "_bclk_c1"}, bclk, 0);
    goto(2); chk({tag, "_bclk_c2"}, bclk, 1);
    goto(3); chk({tag, "_bclk_c3"}, bclk, 1);
    goto(4); chk({tag, "_bclk_c4"}, bclk, 0);
    chk({tag, "_lrclk_c4"}, lrclk, 0);
    chk({tag, "_underrun_c4"}, underrun, 1);
    chk({tag, "_overflow_c4"}, overflow, 0);
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_frames_left"}, exp_q.size(), 0);
  endtask

  // Monitor: counts bclk falls from reset, samples sdata/lrclk on bclk rises, checks each full frame
  initial begin
    int mb = 63;
    bit started = 0;
    logic prev = 1'b0;
    logic [63:0] rec_d = '0;
    logic [63:0] rec_l = '0;
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mb = 63; started = 0; prev = 1'b0;
      end else begin
        if (prev && !bclk) begin
          mb = (mb == 63) ? 0 : mb + 1;
          started = 1;
        end else if (!prev && bclk && started) begin
          rec_d[63-mb] = sdata;
          rec_l[63-mb] = lrclk;
          if (mb == 63) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL frame_unexpected: got %h expected no frame", rec_d);
            end else begin
              e = exp_q.pop_front();
              chk("frame_sdata", rec_d, {e, 16'h0000, e, 16'h0000});
              chk("frame_lrclk", rec_l, LR_EXP);
            end
          end
        end
        prev = bclk;
      end
    end
  end

  initial begin
    reset_n = 1'b0; sample_valid = 1'b0; sample = '0; clear_flags = 1'b0;

    // Reset state with sample_valid asserted, then bclk timing and first-frame underrun
    sample_valid = 1'b1; sample = 16'h7FFF;
    hold_reset();
    chk("rst_bclk", bclk, 0);
    chk("rst_lrclk", lrclk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underrun", underrun, 0);
    sample_valid = 1'b0;
    exp_q.push_back(16'h0000);
    release_and_check("a");
    wait_drain("a");

    // Single sample, then repeat with underrun; clear vs same-cycle set
    hold_reset();
    exp_q.push_back(16'h8001);
    exp_q.push_back(16'h8001);
    reset_n = 1'b1;
    drive(1, 1'b1, 16'h8001, 1'b0);
    chk("b_level_c1", fifo_level, 1);
    goto(3); chk("b_level_c3", fifo_level, 1);
    goto(4); chk("b_level_c4", fifo_level, 0);
    chk("b_underrun_c4", underrun, 0);
    goto(260); chk("b_underrun_repeat", underrun, 1);
    drive(261, 1'b0, 16'h0, 1'b1);
    chk("b_underrun_cleared", underrun, 0);
    wait_drain("b");
    drive(516, 1'b0, 16'h0, 1'b1);
    chk("b_underrun_set_wins", underrun, 1);
    drive(517, 1'b0, 16'h0, 1'b1);
    chk("b_underrun_clear2", underrun, 0);

    // Overflow on 5th push, push during full-FIFO pop, then async reset mid right slot
    hold_reset();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    exp_q.push_back(16'h3333);
    exp_q.push_back(16'h4444);
    exp_q.push_back(16'h6666);
    release_and_check("c");
    drive(5, 1'b1, 16'h1111, 1'b0);
    drive(6, 1'b1, 16'h2222, 1'b0);
    drive(7, 1'b1, 16'h3333, 1'b0);
    drive(8, 1'b1, 16'h4444, 1'b0);
    chk("c_level_full", fifo_level, 4);
    chk("c_overflow_pre", overflow, 0);
    drive(9, 1'b1, 16'h5555, 1'b0);
    chk("c_level_drop", fifo_level, 4);
    chk("c_overflow_set", overflow, 1);
    drive(10, 1'b0, 16'h0, 1'b1);
    chk("c_overflow_cleared", overflow, 0);
    chk("c_underrun_cleared", underrun, 0);
    drive(260, 1'b1, 16'h6666, 1'b0);
    chk("c_level_push_pop", fifo_level, 4);
    chk("c_overflow_push_pop", overflow, 0);
    goto(1284);
    chk("c_level_empty", fifo_level, 0);
    chk("c_underrun_none", underrun, 0);
    wait_drain("c");
    goto(1710);
    chk("c_lrclk_right", lrclk, 1);
    reset_n = 1'b0;
    #1;
    chk("d_async_bclk", bclk, 0);
    chk("d_async_lrclk", lrclk, 0);
    chk("d_async_sdata", sdata, 0);
    chk("d_async_level", fifo_level, 0);
    chk("d_async_underrun", underrun, 0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(16'h0000);
    release_and_check("d");
    wait_drain("d");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
